phase2_root_wr_burst: RTL and testbench
=======================================

// Module: phase2_root_wr_burst
// PURPOSE
//  Drains the phase-2 merge tree root FIFO and writes the sorted stream to memory over an AXI4 write channel.
//  Each root word is split into AXI beats, grouped into fixed-length bursts, and written to incrementing 4 KB-aligned addresses.
//  Bursts are paced by a bounded number of outstanding B responses. o_done is asserted once all responses have returned.
// PARAMETERS
//  DATA_WIDTH      64    record width (bits)
//  BUNDLE_WIDTH    16    leaf bundle width; root word = 2*BUNDLE_WIDTH*DATA_WIDTH bits
//  AXI_DATA_WIDTH  512   AXI W width; RATIO = 2*BUNDLE_WIDTH*DATA_WIDTH/AXI_DATA_WIDTH (integer >=1)
//  ADDR_WIDTH      64    AXI address width
//  BURST_LEN       64    beats per full burst (BURST_LEN*AXI_DATA_WIDTH/8 must be 4096)
//  MAX_OUTSTANDING 4     maximum issued bursts without a B response
// PORTS
//  i_clk            in   1                         clock
//  i_rst_n          in   1                         synchronous active-low reset
//  i_start          in   1                         1-cycle start pulse; ignored while busy
//  i_base_addr      in   ADDR_WIDTH                destination base; bits [11:0] treated as 0
//  i_total_words    in   32                        number of root words to write
//  i_root_data      in   2*BUNDLE_WIDTH*DATA_WIDTH root FIFO head (first-word-fall-through)
//  i_root_data_vld  in   1                         root FIFO non-empty
//  o_root_read      out  1                         pops the root FIFO head
//  o_awaddr/o_awlen/o_awvalid  out  ADDR_WIDTH/8/1 AXI AW; i_awready in 1
//  o_wdata/o_wstrb  out  AXI_DATA_WIDTH/(AXI_DATA_WIDTH/8) AXI W data; wstrb is all ones
//  o_wlast/o_wvalid out  1/1                       AXI W control; i_wready in 1
//  i_bvalid         in   1                         AXI B valid; o_bready out 1 (held at 1 while busy)
//  o_busy/o_done    out  1/1                       o_busy covers start to done; o_done is a 1-cycle pulse
//  o_stall_cycles   out  32                        perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-operation abandons in-flight bursts with no further AXI activity.
//  Beat count: total_beats = i_total_words*RATIO, latched at start.
//  Burst count: bursts = ceil(total_beats/BURST_LEN). The last burst has awlen = rem-1, where rem = total_beats%BURST_LEN, or a full burst if rem==0.
//  FSM states:
//   IDLE: waits for i_start. Goes to DONE if i_total_words==0, else to AW.
//   AW: o_awvalid=1 only when outstanding<MAX_OUTSTANDING. Goes to W on awvalid&awready.
//   W: streams the burst's beats. After the last beat, goes to AW if more bursts remain, else to DRAIN.
//   DRAIN: waits until outstanding==0, then goes to DONE.
//   DONE: o_done=1 for 1 cycle, then IDLE.
//  Addressing: the first burst uses {i_base_addr[ADDR_WIDTH-1:12],12'h0}; each subsequent burst adds 4096 bytes.
//  Beat order: beat k of a root word is i_root_data[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], k=0 first.
//  Beat source: a RATIO-deep beat counter walks the head word.
//  o_root_read: asserted in the same cycle as the handshake of beat RATIO-1, i.e. when wvalid&wready and the head word is fully consumed.
//  o_wvalid: asserted only in W and only when i_root_data_vld=1. There is no bubble between beats when data and wready are both present.
//  Root words may span burst boundaries; the beat counter is not reset at a burst boundary.
//  o_wlast: 1 on beat awlen of the current burst.
//  Outstanding counter:
//   +1 on an AW handshake; -1 on bvalid&bready.
//   A simultaneous AW handshake and B response leaves the count unchanged.
//   The counter never exceeds MAX_OUTSTANDING and never underflows; a B response with outstanding==0 is ignored.
//  Latency: AW can be asserted the cycle after i_start. The first W beat can be asserted the cycle after the AW handshake.
//  i_start while o_busy=1 is ignored. An empty root FIFO simply stalls W, with no timeout.
// CONFIGURATION
//  WR_BURST_PERF_CNT_EN defined:
//   o_stall_cycles counts cycles in the W state with o_wvalid&!i_wready, or with !i_root_data_vld.
//   It also counts AW-state cycles blocked by the outstanding limit.
//   It clears on i_start, saturates at 32'hFFFF_FFFF, and holds after done.
//  WR_BURST_PERF_CNT_EN undefined: o_stall_cycles is tied to 0 and no counter logic is generated.
// TESTING
//  T1: i_total_words=16, RATIO=4, base=0x1_0000, all readies high
//      -> one burst, awaddr=0x1_0000, awlen=63; 64 W beats with wlast on the 64th; 16 root reads; o_done 1 cycle after B.
//  T2: i_total_words=17, base=0x2_0ABC
//      -> bursts at 0x2_0000 (awlen=63) and 0x2_1000 (awlen=3); 68 beats; the word spanning no boundary is read once.
//  T3: i_total_words=0 -> o_done pulses 2 cycles after i_start; o_awvalid and o_wvalid never assert.
//  T4: MAX_OUTSTANDING=2, i_total_words=64, bvalid held low -> exactly 2 AW handshakes, then o_awvalid stays 0.
//      Releasing one B -> the third AW issues.
//  T5: random wready/awready/root_vld gaps, 1000 words
//      -> written data matches the FIFO sequence beat-for-beat; no duplicated or dropped beat.
//  T6: i_rst_n low mid-W for 1 cycle -> all outputs 0 next cycle. A new i_start then completes T1 correctly.
//      With WR_BURST_PERF_CNT_EN, 10 forced wready-low cycles in T1 -> o_stall_cycles=10.

Source files
------------

// File: rtl/phase2_root_wr_burst.sv
// Drains the phase-2 merge-tree root FIFO to memory over an AXI4 write channel.
// Each root word is split into RATIO AXI beats. The beats are grouped into
// BURST_LEN-beat bursts, which are written to consecutive 4 KB-aligned
// addresses. The number of bursts waiting for a B response is capped at
// MAX_OUTSTANDING.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start, i_base_addr,
//   i_total_words             job launch (base is forced to 4 KB alignment)
//   i_root_data(_vld),
//   o_root_read               first-word-fall-through root FIFO head and pop
//   o_aw*, i_awready          AXI write address channel
//   o_w*, i_wready            AXI write data channel (wstrb all ones)
//   i_bvalid, o_bready        AXI write response channel
//   o_busy, o_done            job status; o_done is a 1-cycle pulse
//   o_stall_cycles            stall perf counter
// Build option: define WR_BURST_PERF_CNT_EN to generate the stall counter.
// When it is undefined, o_stall_cycles is tied to 0.
module phase2_root_wr_burst #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BUNDLE_WIDTH    = 16,
    parameter int unsigned AXI_DATA_WIDTH  = 512,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned BURST_LEN       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start,
    input  logic [ADDR_WIDTH-1:0]                  i_base_addr,
    input  logic [31:0]                            i_total_words,
    input  logic [2*BUNDLE_WIDTH*DATA_WIDTH-1:0]   i_root_data,
    input  logic                                   i_root_data_vld,
    output logic                                   o_root_read,
    output logic [ADDR_WIDTH-1:0]                  o_awaddr,
    output logic [7:0]                             o_awlen,
    output logic                                   o_awvalid,
    input  logic                                   i_awready,
    output logic [AXI_DATA_WIDTH-1:0]              o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]            o_wstrb,
    output logic                                   o_wlast,
    output logic                                   o_wvalid,
    input  logic                                   i_wready,
    input  logic                                   i_bvalid,
    output logic                                   o_bready,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic [31:0]                            o_stall_cycles
);
    localparam int unsigned ROOT_W     = 2 * BUNDLE_WIDTH * DATA_WIDTH;
    localparam int unsigned RATIO      = ROOT_W / AXI_DATA_WIDTH;
    localparam int unsigned BEAT_IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BEATS_W    = 32 + BEAT_IDX_W;
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [BEATS_W-1:0]      beats_left;
    logic [BEAT_IDX_W-1:0]   word_beat;
    logic [7:0]              burst_beat;
    logic [OUT_W-1:0]        outstanding;

    logic aw_ok, aw_hs, w_hs, b_dec, word_last;
    logic unused_base_lo;

    // Length field for the next burst, given the number of beats still to send.
    function automatic logic [7:0] calc_len(input logic [BEATS_W-1:0] n);
        if (n >= BEATS_W'(BURST_LEN)) return 8'(BURST_LEN - 1);
        return 8'(n - BEATS_W'(1));
    endfunction

    assign unused_base_lo = ^i_base_addr[11:0];

    // Handshakes and datapath that follow the head word directly
    assign aw_ok       = outstanding < OUT_W'(MAX_OUTSTANDING);
    assign o_awvalid   = (state == S_AW) && aw_ok;
    assign aw_hs       = o_awvalid && i_awready;
    assign o_wvalid    = (state == S_W) && i_root_data_vld;
    assign w_hs        = o_wvalid && i_wready;
    assign word_last   = word_beat == BEAT_IDX_W'(RATIO - 1);
    assign o_wlast     = o_wvalid && (burst_beat == o_awlen);
    assign o_root_read = w_hs && word_last;
    assign o_wdata     = o_wvalid ? i_root_data[word_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                                  : '0;
    assign o_wstrb     = o_wvalid ? '1 : '0;
    assign o_bready    = o_busy;
    // A response that arrives while nothing is outstanding is ignored.
    assign b_dec       = i_bvalid && o_bready && (outstanding != '0);

    // Control FSM, address, beat counters and outstanding tracking
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            beats_left  <= '0;
            word_beat   <= '0;
            burst_beat  <= '0;
            outstanding <= '0;
            o_awaddr    <= '0;
            o_awlen     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case ({aw_hs, b_dec})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy     <= 1'b1;
                        o_awaddr   <= {i_base_addr[ADDR_WIDTH-1:12], 12'h000};
                        beats_left <= BEATS_W'(i_total_words) * BEATS_W'(RATIO);
                        o_awlen    <= calc_len(BEATS_W'(i_total_words) * BEATS_W'(RATIO));
                        word_beat  <= '0;
                        burst_beat <= '0;
                        state      <= (i_total_words == 32'd0) ? S_DONE : S_AW;
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        burst_beat <= '0;
                        state      <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        beats_left <= beats_left - BEATS_W'(1);
                        burst_beat <= burst_beat + 8'd1;
                        // Beat index within the word survives burst boundaries.
                        word_beat  <= word_last ? '0 : word_beat + BEAT_IDX_W'(1);
                        if (o_wlast) begin
                            o_awaddr <= o_awaddr + ADDR_WIDTH'(4096);
                            if (beats_left != BEATS_W'(1)) begin
                                o_awlen <= calc_len(beats_left - BEATS_W'(1));
                                state   <= S_AW;
                            end else begin
                                state   <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) state <= S_DONE;
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WR_BURST_PERF_CNT_EN
    logic        stall;
    logic [31:0] stall_cnt;

    // Cycles lost to backpressure, an empty FIFO, or the outstanding limit
    assign stall = ((state == S_W) && ((o_wvalid && !i_wready) || !i_root_data_vld)) ||
                   ((state == S_AW) && !aw_ok);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && i_start) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_phase2_root_wr_burst.sv
// Directed bench for phase2_root_wr_burst (RATIO=4, BURST_LEN=64, MAX_OUTSTANDING=2).
// Consists of a root FIFO model, an AXI slave with random gaps and a B-response
// gate, and a scoreboard that checks every AW and W handshake against values
// the bench computes itself.
module tb_phase2_root_wr_burst;
    localparam int unsigned MAXO = 2;

    logic            clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic [63:0]     i_base_addr = '0;
    logic [31:0]     i_total_words = '0;
    logic [2047:0]   i_root_data = '0;
    logic            i_root_data_vld = 1'b0;
    logic            o_root_read;
    logic [63:0]     o_awaddr;
    logic [7:0]      o_awlen;
    logic            o_awvalid;
    logic            i_awready = 1'b0;
    logic [511:0]    o_wdata;
    logic [63:0]     o_wstrb;
    logic            o_wlast;
    logic            o_wvalid;
    logic            i_wready = 1'b0;
    logic            i_bvalid = 1'b0;
    logic            o_bready;
    logic            o_busy;
    logic            o_done;
    logic [31:0]     o_stall_cycles;

    phase2_root_wr_burst #(.MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_total_words(i_total_words), .i_root_data(i_root_data),
        .i_root_data_vld(i_root_data_vld), .o_root_read(o_root_read),
        .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_busy(o_busy), .o_done(o_done), .o_stall_cycles(o_stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Root word idx: 32 records of {idx, salted record number}.
    function automatic logic [2047:0] gen_word(input int idx);
        logic [2047:0] w;
        for (int r = 0; r < 32; r++) w[r*64 +: 64] = {32'(idx), 32'(r) ^ 32'hC0DE_0000};
        return w;
    endfunction

    // Model state
    int          fifo_idx = 0, fifo_words = 0, total_beats = 0;
    bit          pop_pend = 0, rnd = 0;
    int          b_limit = -1, force_low = 0;
    int          aw_cnt = 0, beat_cnt = 0, burst_beat = 0, reads = 0;
    int          b_pend = 0, b_cnt = 0, done_seen = 0, awv_seen = 0, wv_seen = 0;
    logic [7:0]  cur_len = '0;
    logic [63:0] base_al = '0;

    // Drive the FIFO/slave on negedge; check the handshakes of the coming posedge.
    always @(negedge clk) begin
        logic [2047:0] w;
        logic [511:0]  exp_beat;
        int            k, rem;
        if (pop_pend) begin fifo_idx++; pop_pend = 0; end
        i_root_data     = gen_word(fifo_idx);
        i_root_data_vld = (fifo_idx < fifo_words) && (!rnd || $urandom_range(0, 3) != 0);
        i_wready        = (force_low == 0) && (!rnd || $urandom_range(0, 2) != 0);
        i_awready       = !rnd || $urandom_range(0, 1) != 0;
        i_bvalid        = (b_pend > 0) && (b_limit != 0) && (!rnd || $urandom_range(0, 1) != 0);
        #1;
        if (i_rst_n) begin
            if (o_awvalid) awv_seen++;
            if (o_wvalid) wv_seen++;
            if (o_awvalid && i_awready) begin
                rem     = total_beats - aw_cnt * 64;
                cur_len = (rem >= 64) ? 8'd63 : 8'(rem - 1);
                chk("awaddr", o_awaddr, base_al + 64'(aw_cnt) * 64'h1000);
                chk("awlen", o_awlen, cur_len);
                chk("outstanding", (aw_cnt - b_cnt) < MAXO, 1'b1);
                aw_cnt++;
                burst_beat = 0;
            end
            if (o_wvalid && i_wready) begin
                w        = gen_word(beat_cnt / 4);
                k        = beat_cnt % 4;
                exp_beat = w[k*512 +: 512];
                chk("wdata", o_wdata, exp_beat);
                chk("wstrb", o_wstrb, {64{1'b1}});
                chk("wlast", o_wlast, burst_beat == int'(cur_len));
                chk("root_read", o_root_read, k == 3);
                if (o_wlast) b_pend++;
                beat_cnt++;
                burst_beat++;
            end else if (o_root_read) begin
                chk("root_read_idle", o_root_read, 1'b0);
            end
            if (o_root_read) begin pop_pend = 1; reads++; end
            if (i_bvalid && o_bready) begin
                b_pend--; b_cnt++;
                if (b_limit > 0) b_limit--;
            end
            if ((force_low > 0) && o_wvalid && !i_wready) force_low--;
            if (o_done) done_seen++;
        end
    end

    task automatic arm(input int words, input logic [63:0] base, input bit gaps,
                       input int wlow, input int blim);
        @(posedge clk);
        fifo_idx = 0; fifo_words = words; pop_pend = 0; total_beats = words * 4;
        aw_cnt = 0; beat_cnt = 0; burst_beat = 0; reads = 0; b_pend = 0; b_cnt = 0;
        done_seen = 0; awv_seen = 0; wv_seen = 0; cur_len = '0;
        base_al = base & ~64'hFFF; rnd = gaps; force_low = wlow; b_limit = blim;
        i_base_addr = base; i_total_words = 32'(words);
    endtask

    task automatic fire();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_seen == 0; i++) @(posedge clk);
        if (done_seen == 0) chk(tag, 1'b0, 1'b1);
    endtask

    task automatic end_checks(input string tag, input int words);
        @(negedge clk); #2;
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_beats"}, beat_cnt, words * 4);
        chk({tag, "_reads"}, reads, words);
        chk({tag, "_bursts"}, aw_cnt, (words * 4 + 63) / 64);
        chk({tag, "_bresp"}, b_cnt, (words * 4 + 63) / 64);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_seen, 1);
    endtask

    task automatic run_xfer(input string tag, input int words, input logic [63:0] base,
                            input bit gaps, input int wlow, input int budget);
        arm(words, base, gaps, wlow, -1);
        fire();
        #2;
        if (!gaps) chk({tag, "_aw_lat"}, o_awvalid, 1'b1);
        wait_done({tag, "_done_timeout"}, budget);
        end_checks(tag, words);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_awvalid", o_awvalid, 1'b0);
        chk("rst_wvalid", o_wvalid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_bready", o_bready, 1'b0);
        chk("rst_stall", o_stall_cycles, 32'd0);
        @(negedge clk); i_rst_n = 1'b1;

        // T1: one full burst
        run_xfer("t1", 16, 64'h1_0000, 1'b0, 0, 2000);
        // T2: full burst plus a 4-beat tail, unaligned base
        run_xfer("t2", 17, 64'h2_0ABC, 1'b0, 0, 2000);

        // T3: zero words
        arm(0, 64'h5000, 1'b0, 0, -1);
        fire();
        #2; chk("t3_done_early", o_done, 1'b0);
        @(negedge clk); #2; chk("t3_done", o_done, 1'b1);
        @(negedge clk); #2; chk("t3_done_end", o_done, 1'b0);
        chk("t3_busy", o_busy, 1'b0);
        chk("t3_awvalid_seen", awv_seen, 0);
        chk("t3_wvalid_seen", wv_seen, 0);

        // T4: outstanding limit with B held back
        arm(64, 64'h4_0000, 1'b0, 0, 0);
        fire();
        repeat (400) @(posedge clk);
        @(negedge clk); #2;
        chk("t4_aw_blocked", aw_cnt, 2);
        chk("t4_awvalid_low", o_awvalid, 1'b0);
        chk("t4_beats", beat_cnt, 128);
        b_limit = 1;
        repeat (6) @(negedge clk);
        #2; chk("t4_third_aw", aw_cnt, 3);
        b_limit = -1;
        wait_done("t4_done_timeout", 2000);
        end_checks("t4", 64);

        // T5: random gaps on every handshake
        run_xfer("t5", 1000, 64'h80_0123, 1'b1, 0, 40000);

        // T6: reset mid-W, then a clean rerun with forced wready stalls
        arm(16, 64'h1_0000, 1'b0, 0, -1);
        fire();
        for (int i = 0; i < 200 && beat_cnt < 20; i++) @(posedge clk);
        chk("t6_reach_w", beat_cnt >= 20, 1'b1);
        @(negedge clk); i_rst_n = 1'b0;
        @(negedge clk); i_rst_n = 1'b1;
        #2;
        chk("t6_awvalid", o_awvalid, 1'b0);
        chk("t6_wvalid", o_wvalid, 1'b0);
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_bready", o_bready, 1'b0);
        chk("t6_root_read", o_root_read, 1'b0);
        chk("t6_awaddr", o_awaddr, 64'h0);
        chk("t6_awlen", o_awlen, 8'h0);
        run_xfer("t6", 16, 64'h1_0000, 1'b0, 10, 2000);
`ifdef WR_BURST_PERF_CNT_EN
        chk("t6_stall", o_stall_cycles, 32'd10);
`else
        chk("t6_stall", o_stall_cycles, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
